// File: rtl/ysyx_23060201_wbu.sv
// ============================================================================
// Module   : ysyx_23060201_wbu
// Purpose  : GPR write-back unit; LSU/EXU arbitration, in-order queue,
//            registered write port, pending mask, optional forwarding lookup
//            (enabled by YSYX_23060201_WBU_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060201_wbu #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exu_valid_i,
    output logic                         exu_ready_o,
    input  logic [GPR_ADDR_WIDTH-1:0]    exu_rd_i,
    input  logic [DATA_WIDTH-1:0]        exu_wdata_i,
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [GPR_ADDR_WIDTH-1:0]    lsu_rd_i,
    input  logic [DATA_WIDTH-1:0]        lsu_wdata_i,
    output logic                         gpr_wen_o,
    output logic [GPR_ADDR_WIDTH-1:0]    gpr_waddr_o,
    output logic [DATA_WIDTH-1:0]        gpr_wdata_o,
    output logic [2**GPR_ADDR_WIDTH-1:0] pend_mask_o,
    input  logic [GPR_ADDR_WIDTH-1:0]    fwd_raddr_i,
    output logic                         fwd_hit_o,
    output logic [DATA_WIDTH-1:0]        fwd_data_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**GPR_ADDR_WIDTH;

    logic [GPR_ADDR_WIDTH-1:0] rd_q   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]     data_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      gpr_wen_q;
    logic [GPR_ADDR_WIDTH-1:0] gpr_waddr_q;
    logic [DATA_WIDTH-1:0]     gpr_wdata_q;

    logic                      full, pop, push, lsu_fire, exu_fire;
    logic [GPR_ADDR_WIDTH-1:0] push_rd;
    logic [DATA_WIDTH-1:0]     push_data;
    logic [QUEUE_DEPTH-1:0]    live;
    logic [NREG-1:0]           mask;

    // Full is taken from registered occupancy only: a same-cycle pop never frees a slot.
    assign full        = (cnt_q == CNT_W'(QUEUE_DEPTH));
    assign pop         = (cnt_q != '0);
    assign lsu_ready_o = !rst && !full;
    assign exu_ready_o = !rst && !full && !lsu_valid_i;
    assign lsu_fire    = lsu_valid_i && lsu_ready_o;
    assign exu_fire    = exu_valid_i && exu_ready_o;
    assign push_rd     = lsu_fire ? lsu_rd_i    : exu_rd_i;
    assign push_data   = lsu_fire ? lsu_wdata_i : exu_wdata_i;
    assign push        = (lsu_fire || exu_fire) && (push_rd != '0);

    always_comb begin
        head_d = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d = push ? tail_q + PTR_W'(1) : tail_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            gpr_wen_q <= pop;
            if (push) begin
                rd_q[tail_q]   <= push_rd;
                data_q[tail_q] <= push_data;
            end
            if (pop) begin
                gpr_waddr_q <= rd_q[head_q];
                gpr_wdata_q <= data_q[head_q];
            end
        end
    end

    always_comb begin
        live = '0;
        mask = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            live[i] = ({1'b0, PTR_W'(i) - head_q} < cnt_q);
            if (live[i]) mask[rd_q[i]] = 1'b1;
        end
        if (gpr_wen_q) mask[gpr_waddr_q] = 1'b1;
        mask[0] = 1'b0;
    end

    assign pend_mask_o = mask;
    assign gpr_wen_o   = gpr_wen_q;
    assign gpr_waddr_o = gpr_waddr_q;
    assign gpr_wdata_o = gpr_wdata_q;

`ifdef YSYX_23060201_WBU_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest so the last (tail-most) match wins over the output stage.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        if (fwd_raddr_i != '0) begin
            if (gpr_wen_q && (gpr_waddr_q == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = gpr_wdata_q;
            end
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
                fwd_idx = head_q + PTR_W'(k);
                if ((CNT_W'(k) < cnt_q) && (rd_q[fwd_idx] == fwd_raddr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = data_q[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_fwd_raddr;
    assign unused_fwd_raddr = ^fwd_raddr_i;
    assign fwd_hit_o        = 1'b0;
    assign fwd_data_o       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060201_wbu.sv
// ============================================================================
// Module   : tb_ysyx_23060201_wbu
// Purpose  : Self-checking bench for ysyx_23060201_wbu against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060201_wbu;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int QD = 4;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [AW-1:0] exu_rd, lsu_rd, fwd_raddr;
    logic [DW-1:0] exu_wdata, lsu_wdata;
    logic          gpr_wen, fwd_hit;
    logic [AW-1:0] gpr_waddr;
    logic [DW-1:0] gpr_wdata, fwd_data;
    logic [31:0]   pend_mask;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    entry_t        mq[$];
    logic          m_wen   = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_lsu_acc = 1'b0;
    logic          m_exu_acc = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060201_wbu #(
        .GPR_ADDR_WIDTH(AW),
        .DATA_WIDTH    (DW),
        .QUEUE_DEPTH   (QD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid_i(exu_valid),
        .exu_ready_o(exu_ready),
        .exu_rd_i   (exu_rd),
        .exu_wdata_i(exu_wdata),
        .lsu_valid_i(lsu_valid),
        .lsu_ready_o(lsu_ready),
        .lsu_rd_i   (lsu_rd),
        .lsu_wdata_i(lsu_wdata),
        .gpr_wen_o  (gpr_wen),
        .gpr_waddr_o(gpr_waddr),
        .gpr_wdata_o(gpr_wdata),
        .pend_mask_o(pend_mask),
        .fwd_raddr_i(fwd_raddr),
        .fwd_hit_o  (fwd_hit),
        .fwd_data_o (fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance both by one edge.
    task automatic step();
        logic [31:0]   e_mask;
        logic          e_hit;
        logic [DW-1:0] e_fdata;
        @(negedge clk);
        e_mask = '0;
        foreach (mq[i]) e_mask[mq[i].rd] = 1'b1;
        if (m_wen) e_mask[m_waddr] = 1'b1;
        e_mask[0] = 1'b0;
        e_hit   = 1'b0;
        e_fdata = '0;
`ifdef YSYX_23060201_WBU_FWD_EN
        if (fwd_raddr != '0) begin
            if (m_wen && m_waddr == fwd_raddr) begin
                e_hit = 1'b1; e_fdata = m_wdata;
            end
            foreach (mq[i]) if (mq[i].rd == fwd_raddr) begin
                e_hit = 1'b1; e_fdata = mq[i].d;
            end
        end
`endif
        chk("lsu_ready", 64'(lsu_ready), 64'(!rst && mq.size() < QD));
        chk("exu_ready", 64'(exu_ready), 64'(!rst && mq.size() < QD && !lsu_valid));
        chk("gpr_wen",   64'(gpr_wen),   64'(m_wen));
        chk("gpr_waddr", 64'(gpr_waddr), 64'(m_waddr));
        chk("gpr_wdata", 64'(gpr_wdata), 64'(m_wdata));
        chk("pend_mask", 64'(pend_mask), 64'(e_mask));
        chk("fwd_hit",   64'(fwd_hit),   64'(e_hit));
        chk("fwd_data",  64'(fwd_data),  64'(e_fdata));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
            m_lsu_acc = 1'b0; m_exu_acc = 1'b0;
        end else begin
            m_lsu_acc = lsu_valid && mq.size() < QD;
            m_exu_acc = exu_valid && mq.size() < QD && !lsu_valid;
            if (mq.size() > 0) begin
                entry_t h;
                h = mq.pop_front();
                m_wen = 1'b1; m_waddr = h.rd; m_wdata = h.d;
            end else begin
                m_wen = 1'b0;
            end
            if (m_lsu_acc && lsu_rd != '0) mq.push_back('{rd: lsu_rd, d: lsu_wdata});
            if (m_exu_acc && exu_rd != '0) mq.push_back('{rd: exu_rd, d: exu_wdata});
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        exu_valid = 1'b0; exu_rd = '0; exu_wdata = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
        fwd_raddr = '0;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single EXU push into an idle unit
        fwd_raddr = 5'd5;
        exu_valid = 1'b1; exu_rd = 5'd5; exu_wdata = 32'h1234;
        step();
        exu_valid = 1'b0;
        idle(3);

        // Simultaneous LSU/EXU: LSU first, EXU held until accepted
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'hA;
        exu_valid = 1'b1; exu_rd = 5'd4; exu_wdata = 32'hB;
        step();
        lsu_valid = 1'b0;
        step();
        exu_valid = 1'b0;
        idle(3);

        // Back-to-back EXU pushes
        for (int i = 0; i < 6; i++) begin
            exu_valid = 1'b1; exu_rd = 5'(i + 1); exu_wdata = $urandom;
            step();
        end
        exu_valid = 1'b0;
        idle(3);

        // rd == 0 is discarded
        exu_valid = 1'b1; exu_rd = 5'd0; exu_wdata = 32'hFFFF;
        step();
        exu_valid = 1'b0;
        idle(3);

        // Two writes to x7: youngest value must be forwarded
        fwd_raddr = 5'd7;
        exu_valid = 1'b1; exu_rd = 5'd7; exu_wdata = 32'h11;
        step();
        exu_wdata = 32'h22;
        step();
        exu_valid = 1'b0;
        idle(3);

        // Reset while entries are in flight
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(9 + i); lsu_wdata = $urandom;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; lsu_valid = 1'b0;
        idle(3);

        // Randomized traffic with producers holding until accepted
        for (int c = 0; c < 3000; c++) begin
            if (!lsu_valid || m_lsu_acc) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                lsu_wdata = $urandom;
            end
            if (!exu_valid || m_exu_acc) begin
                exu_valid = ($urandom_range(0, 1) == 0);
                exu_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                exu_wdata = $urandom;
            end
            fwd_raddr = 5'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; lsu_valid = 1'b0; exu_valid = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060201_wbu.md
# ysyx_23060201_wbu

Write-back unit that sits between the execution-side producers (EXU results, LSU load data) and the register file's single write port. It accepts results through valid/ready handshakes, arbitrates between the two producers, buffers them in a small in-order queue, and drains one entry per cycle onto registered `gpr_wen`/`gpr_waddr`/`gpr_wdata`. It also exports a pending-write mask for decode-stage hazard stalls.

## Interface
- `GPR_ADDR_WIDTH`, 5, register index width
- `DATA_WIDTH`, 32, data width
- `QUEUE_DEPTH`, 4, queue entries; power of two, ≥2

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `exu_valid`  in  1  EXU result valid
- `exu_ready`  out  1  EXU result accepted this cycle
- `exu_rd`  in  GPR_ADDR_WIDTH  EXU destination register
- `exu_wdata`  in  DATA_WIDTH  EXU result
- `lsu_valid`  in  1  LSU load data valid
- `lsu_ready`  out  1  LSU data accepted this cycle
- `lsu_rd`  in  GPR_ADDR_WIDTH  LSU destination register
- `lsu_wdata`  in  DATA_WIDTH  LSU load data
- `gpr_wen`  out  1  register-file write enable (registered)
- `gpr_waddr`  out  GPR_ADDR_WIDTH  write address (registered)
- `gpr_wdata`  out  DATA_WIDTH  write data (registered)
- `pend_mask`  out  2**GPR_ADDR_WIDTH  bit i = write to x_i queued or in output stage
- `fwd_raddr`  in  GPR_ADDR_WIDTH  forwarding lookup address
- `fwd_hit`  out  1  lookup hit
- `fwd_data`  out  DATA_WIDTH  youngest pending value for `fwd_raddr`

## Operation
- Queue: circular buffer of `{rd, data}`; head/tail pointers wrap modulo QUEUE_DEPTH; occupancy counter 0..QUEUE_DEPTH.
- Arbitration: fixed priority, LSU over EXU; at most one push per cycle.
- `lsu_ready = !rst && !full`; `exu_ready = !rst && !full && !lsu_valid`.
- `full` is the registered occupancy == QUEUE_DEPTH; a same-cycle pop does not free a slot for a push (no pass-through).
- Handshake completes on `valid && ready` at a rising edge. Producers hold `rd`/data stable until accepted.
- rd == 0: handshake completes normally, entry is discarded and never enqueued, never written, never sets `pend_mask`.
- Drain: each cycle the queue is non-empty, the head pops into the output stage: `gpr_wen<=1`, `gpr_waddr<=rd`, `gpr_wdata<=data`. When empty: `gpr_wen<=0`; addr/data hold their last values.
- Order: entries written to the GPR strictly in acceptance order.
- `pend_mask`: combinational OR of one-hot(rd) over valid queue entries plus the output stage when `gpr_wen=1`. Bit 0 always 0.
- Reset: queue empty, pointers 0, `gpr_wen=0`, `gpr_waddr=0`, `gpr_wdata=0`, `pend_mask=0`, `fwd_hit=0`, both readies 0 while `rst` high. Reset mid-drain drops all queued entries; no write issued after the reset edge.

## Timing
- Push accepted at edge N → entry in queue after N.
- If the queue was empty, pop at edge N+1 → `gpr_wen=1` during cycle N+1..N+2 → GPR written at edge N+2. Minimum accept-to-write latency: 2 edges.
- Throughput: 1 write per cycle sustained; full queue accepts again the cycle after occupancy drops.
- `pend_mask`, `fwd_hit`, `fwd_data`, readies: combinational from registered state plus `lsu_valid` (readies only). No combinational path from `*_wdata` to any output.

## Configuration
- `YSYX_23060201_WBU_FWD_EN` defined: `fwd_hit=1` when `fwd_raddr != 0` and matches a valid queue entry or the active output stage. `fwd_data` comes from the youngest match; queue tail-most entry outranks the output stage.
- Undefined: no lookup logic; `fwd_hit=0`, `fwd_data=0`; `fwd_raddr` ignored.

## Test plan
- Single EXU push rd=5, data=0x1234 into an idle unit → `gpr_wen=1`, waddr=5, wdata=0x1234 exactly one cycle, 2 edges after accept. `pend_mask[5]` high from accept until that write cycle ends.
- LSU (rd=3, 0xA) and EXU (rd=4, 0xB) valid in the same cycle → LSU accepted, `exu_ready=0`. EXU accepted next cycle. Writes x3 then x4 on consecutive cycles.
- Six back-to-back EXU pushes with a stalled drain impossible; instead QUEUE_DEPTH=4, pushes every cycle → readies never drop below 1-per-cycle throughput after fill. Writes appear in order, none lost.
- Push rd=0, data=0xFFFF → handshake completes, `gpr_wen` stays 0, `pend_mask=0`.
- Three entries queued, `rst` asserted one cycle → `gpr_wen=0` from the next cycle on, `pend_mask=0`, no further writes.
- FWD_EN: queue holds x7=0x11 then x7=0x22, lookup `fwd_raddr=7` → `fwd_hit=1`, `fwd_data=0x22`. With the macro undefined → `fwd_hit=0`.
